// File: rtl/mem_stage.sv
// Memory stage: issues load/store accesses over a req/ack port, stalls upstream
// while an access is outstanding, and registers the MEM/WB bundle.
module mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_W      = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_mem_readmem,
  input  logic                  ex_mem_writemem,
  input  logic [DATA_WIDTH-1:0] ex_mem_regb,
  input  logic                  ex_mem_selwsource,
  input  logic [REG_W-1:0]      ex_mem_regdest,
  input  logic                  ex_mem_writereg,
  input  logic [DATA_WIDTH-1:0] ex_mem_wbvalue,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_stall,
  output logic                  mem_err,
  output logic [REG_W-1:0]      mem_wb_regdest,
  output logic                  mem_wb_writereg,
  output logic [DATA_WIDTH-1:0] mem_wb_wbvalue
);

  // Counter only has to reach TIMEOUT-1; one spare code lets it saturate when TIMEOUT=0.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [REG_W-1:0] regdest;
    logic             writereg;
    logic             sel;
  } pend_t;

  state_t          state;
  pend_t           pend;
  logic [CW-1:0]   count;
  logic            op;
  logic            timeout_hit;

  assign op = ex_mem_readmem | ex_mem_writemem;

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      assign timeout_hit = (state == WAIT) && (count == CW'(TIMEOUT - 1)) && !mem_ack;
    end
  endgenerate

  assign mem_stall = ((state == IDLE) && op) ||
                     ((state == WAIT) && !mem_ack && !timeout_hit);

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      pend            <= '0;
      count           <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_err         <= 1'b0;
      mem_wb_regdest  <= '0;
      mem_wb_writereg <= 1'b0;
      mem_wb_wbvalue  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op) begin
            // A simultaneous read+write request is treated as a store.
            mem_req         <= 1'b1;
            mem_we          <= ex_mem_writemem;
            mem_addr        <= ex_mem_wbvalue;
            mem_wdata       <= ex_mem_regb;
            pend.regdest    <= ex_mem_regdest;
            pend.writereg   <= ex_mem_writereg;
            pend.sel        <= ex_mem_selwsource;
            count           <= '0;
            mem_wb_writereg <= 1'b0;
            state           <= WAIT;
          end else begin
            mem_wb_regdest  <= ex_mem_regdest;
            mem_wb_writereg <= ex_mem_writereg;
            if (ex_mem_writereg)
              mem_wb_wbvalue <= ex_mem_wbvalue;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req         <= 1'b0;
            mem_wb_regdest  <= pend.regdest;
            mem_wb_writereg <= pend.writereg;
            if (pend.writereg)
              mem_wb_wbvalue <= pend.sel ? mem_rdata : mem_addr;
            state           <= IDLE;
          end else if (timeout_hit) begin
            mem_req         <= 1'b0;
            mem_err         <= 1'b1;
            mem_wb_writereg <= 1'b0;
            state           <= IDLE;
          end else begin
            mem_wb_writereg <= 1'b0;
            if (count != '1)
              count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table-driven pass-through vectors plus
// hand-written load/store/timeout/reset sequences (TIMEOUT=8).
module tb_mem_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg;
  logic [DW-1:0] ex_mem_regb, ex_mem_wbvalue;
  logic [RW-1:0] ex_mem_regdest;
  logic          mem_req, mem_we, mem_ack, mem_stall, mem_err, mem_wb_writereg;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata, mem_wb_wbvalue;
  logic [RW-1:0] mem_wb_regdest;

  int ncmp = 0;
  int nerr = 0;

  mem_stage #(.DATA_WIDTH(DW), .REG_W(RW), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
    .ex_mem_regb(ex_mem_regb), .ex_mem_selwsource(ex_mem_selwsource),
    .ex_mem_regdest(ex_mem_regdest), .ex_mem_writereg(ex_mem_writereg),
    .ex_mem_wbvalue(ex_mem_wbvalue),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_err(mem_err),
    .mem_wb_regdest(mem_wb_regdest), .mem_wb_writereg(mem_wb_writereg),
    .mem_wb_wbvalue(mem_wb_wbvalue)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] wbvalue;
    logic [RW-1:0] regdest;
    logic          writereg;
    logic [RW-1:0] exp_regdest;
    logic          exp_writereg;
    logic [DW-1:0] exp_wbvalue;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ex();
    ex_mem_readmem = 0; ex_mem_writemem = 0; ex_mem_selwsource = 0;
    ex_mem_writereg = 0; ex_mem_regb = '0; ex_mem_wbvalue = '0; ex_mem_regdest = '0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic sel, input logic [RW-1:0] rd_idx,
                       input logic wreg, input logic [DW-1:0] addr, input logic [DW-1:0] data);
    ex_mem_readmem = rd; ex_mem_writemem = wr; ex_mem_selwsource = sel;
    ex_mem_regdest = rd_idx; ex_mem_writereg = wreg; ex_mem_wbvalue = addr; ex_mem_regb = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h2A,         5'd5,  1'b1, 5'd5,  1'b1, 32'h2A};
    vecs[1] = '{32'h1234_5678,  5'd31, 1'b1, 5'd31, 1'b1, 32'h1234_5678};
    vecs[2] = '{32'hFFFF_FFFF,  5'd0,  1'b1, 5'd0,  1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{32'h55,         5'd7,  1'b0, 5'd7,  1'b0, 32'hFFFF_FFFF};
    vecs[4] = '{32'h0,          5'd3,  1'b1, 5'd3,  1'b1, 32'h0};

    // Reset
    reset = 1; mem_ack = 0; mem_rdata = '0; clear_ex();
    step(); step();
    chk("rst_req", mem_req, 0); chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", mem_err, 0); chk("rst_stall", mem_stall, 0);
    chk("rst_wb", {mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue}, 0);
    reset = 0;

    // ALU pass-through table
    for (int i = 0; i < 5; i++) begin
      issue(0, 0, 0, vecs[i].regdest, vecs[i].writereg, vecs[i].wbvalue, '0);
      #1 chk("pt_stall", mem_stall, 0);
      step();
      chk("pt_regdest", mem_wb_regdest, vecs[i].exp_regdest);
      chk("pt_writereg", mem_wb_writereg, vecs[i].exp_writereg);
      chk("pt_wbvalue", mem_wb_wbvalue, vecs[i].exp_wbvalue);
    end

    // LW, ack in 3rd WAIT cycle
    issue(1, 0, 1, 5'd8, 1, 32'h100, 32'h0);
    #1 chk("lw_stall_idle", mem_stall, 1);
    step();
    chk("lw_req", mem_req, 1); chk("lw_we", mem_we, 0); chk("lw_addr", mem_addr, 32'h100);
    chk("lw_bubble", mem_wb_writereg, 0);
    chk("lw_stall_w1", mem_stall, 1);
    step();
    chk("lw_stall_w2", mem_stall, 1); chk("lw_req_hold", mem_req, 1);
    step();
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    #1 chk("lw_stall_ack", mem_stall, 0);
    step();
    mem_ack = 0; clear_ex();
    chk("lw_wb", {mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue}, {5'd8, 1'b1, 32'hDEAD_BEEF});
    chk("lw_req_done", mem_req, 0);

    // SW, ack in 1st WAIT cycle; write-back value must hold
    issue(0, 1, 0, 5'd9, 0, 32'h40, 32'd31);
    #1 chk("sw_stall_idle", mem_stall, 1);
    step();
    chk("sw_req", mem_req, 1); chk("sw_we", mem_we, 1);
    chk("sw_wdata", mem_wdata, 32'd31); chk("sw_addr", mem_addr, 32'h40);
    mem_ack = 1;
    #1 chk("sw_stall_ack", mem_stall, 0);
    step();
    mem_ack = 0; clear_ex();
    chk("sw_writereg", mem_wb_writereg, 0); chk("sw_wb_hold", mem_wb_wbvalue, 32'hDEAD_BEEF);
    chk("sw_req_done", mem_req, 0);

    // read+write both set acts as a write; sel=0 writes back the address
    issue(1, 1, 0, 5'd4, 1, 32'h80, 32'h11);
    step();
    chk("rw_we", mem_we, 1);
    mem_ack = 1; mem_rdata = 32'h99;
    step();
    mem_ack = 0; clear_ex();
    chk("rw_wb", {mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue}, {5'd4, 1'b1, 32'h80});

    // Timeout: no ack for 8 WAIT cycles
    issue(1, 0, 1, 5'd12, 1, 32'h200, 32'h0);
    step();
    for (int i = 1; i <= 8; i++) begin
      chk("to_stall", mem_stall, (i < 8) ? 1'b1 : 1'b0);
      chk("to_err_pre", mem_err, 0);
      step();
    end
    clear_ex();
    #1 chk("to_req", mem_req, 0);
    chk("to_err", mem_err, 1); chk("to_writereg", mem_wb_writereg, 0);
    chk("to_wb_hold", mem_wb_wbvalue, 32'h80);
    chk("to_stall_after", mem_stall, 0);

    // ack in IDLE ignored; mem_err stays sticky
    issue(0, 0, 0, 5'd2, 1, 32'h77, 32'h0);
    mem_ack = 1; mem_rdata = 32'h1;
    step();
    mem_ack = 0; clear_ex();
    chk("idle_ack_req", mem_req, 0);
    chk("idle_ack_wb", {mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue}, {5'd2, 1'b1, 32'h77});
    chk("err_sticky", mem_err, 1);

    // ack coincides with the timeout cycle: ack wins
    issue(1, 0, 1, 5'd13, 1, 32'h300, 32'h0);
    step();
    for (int i = 1; i < 8; i++) step();
    mem_ack = 1; mem_rdata = 32'hCAFE;
    #1 chk("tie_stall", mem_stall, 0);
    step();
    mem_ack = 0; clear_ex();
    chk("tie_wb", {mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue}, {5'd13, 1'b1, 32'hCAFE});
    chk("tie_req", mem_req, 0);

    // Reset during WAIT, then a late ack
    issue(1, 0, 1, 5'd10, 1, 32'h300, 32'h0);
    step();
    chk("rw_req_pre", mem_req, 1);
    reset = 1;
    step();
    reset = 0; clear_ex();
    chk("rstw_req", mem_req, 0); chk("rstw_err", mem_err, 0);
    chk("rstw_writereg", mem_wb_writereg, 0);
    mem_ack = 1; mem_rdata = 32'hBAD;
    #1 chk("rstw_stall", mem_stall, 0);
    step();
    mem_ack = 0;
    chk("late_ack_wb", {mem_wb_writereg, mem_wb_wbvalue}, {1'b0, 32'h0});
    chk("late_ack_req", mem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
